board_move_sequencer: RTL and testbench

BOARD_MOVE_SEQUENCER -- requirements
Module: board_move_sequencer

---
 rtl/board_move_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_board_move_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_move_sequencer.sv
// 4x4 sliding-tile game engine: slides one line per cycle, merges equal tiles,
// spawns new tiles from an LFSR and flags win/loss.
module board_move_sequencer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned WIN_EXP   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dir,
  input  logic        load,
  input  logic [63:0] load_board,
  output logic [63:0] board,
  output logic [15:0] score,
  output logic        win,
  output logic        loss,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StInit0, StInit1, StIdle, StSlide, StSpawn, StCheck, StOver
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] board_q, board_d;
  logic [15:0] score_q, score_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  dir_q, dir_d;
  logic [1:0]  idx_q, idx_d;
  logic        win_q, win_d, loss_q, loss_d, busy_q, busy_d, done_q, done_d;
  logic        moved_q, moved_d, from_spawn_q, from_spawn_d;

  logic [15:0] line_in, line_out;
  logic [17:0] line_gain;
  logic [18:0] score_sum;
  logic [63:0] slide_board, spawn_board;
  logic [3:0]  spawn_idx;
  logic        spawn_found;
  logic        any_win, any_empty, any_pair;

  // Cell index {row, col} of position pos (leading-first) within the given line number.
  function automatic logic [3:0] line_cell(input logic [3:0] d, input logic [1:0] line,
                                           input logic [1:0] pos);
    logic [1:0] rpos;
    rpos = 2'd3 - pos;
    if (d[3])      return {pos, line};
    else if (d[2]) return {rpos, line};
    else if (d[1]) return {line, pos};
    else           return {line, rpos};
  endfunction

  function automatic void slide_line(input logic [15:0] lin, output logic [15:0] lout,
                                     output logic [17:0] gain);
    logic [3:0] cells [5];
    logic [2:0] n;
    logic [2:0] o;
    logic       skip;
    for (int i = 0; i < 5; i++) cells[i] = '0;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (lin[4*i +: 4] != 4'd0) begin
        cells[n] = lin[4*i +: 4];
        n = n + 3'd1;
      end
    end
    lout = '0;
    gain = '0;
    o    = '0;
    skip = 1'b0;
    // cells[4] is always zero, so the last compacted tile never pairs past the end.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cells[i] != 4'd0) begin
        if (cells[i] == cells[i+1]) begin
          lout[4*o +: 4] = cells[i] + 4'd1;
          gain = gain + (18'd1 << ({1'b0, cells[i]} + 5'd1));
          skip = 1'b1;
        end else begin
          lout[4*o +: 4] = cells[i];
        end
        o = o + 3'd1;
      end
    end
  endfunction

  always_comb begin
    line_in = '0;
    for (int j = 0; j < 4; j++) begin
      line_in[4*j +: 4] = board_q[4*line_cell(dir_q, idx_q, 2'(j)) +: 4];
    end
    slide_line(line_in, line_out, line_gain);
    slide_board = board_q;
    for (int j = 0; j < 4; j++) begin
      slide_board[4*line_cell(dir_q, idx_q, 2'(j)) +: 4] = line_out[4*j +: 4];
    end
    score_sum = {3'b000, score_q} + {1'b0, line_gain};
  end

  always_comb begin
    spawn_board = board_q;
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int k = 0; k < 16; k++) begin
      spawn_idx = lfsr_q[3:0] + 4'(k);
      if (!spawn_found && board_q[4*spawn_idx +: 4] == 4'd0) begin
        spawn_board[4*spawn_idx +: 4] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
        spawn_found = 1'b1;
      end
    end
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (32'(board_q[4*i +: 4]) >= WIN_EXP) any_win = 1'b1;
      if (board_q[4*i +: 4] == 4'd0) any_empty = 1'b1;
    end
    // Same loop covers horizontal pairs (row r) and vertical pairs (column r).
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (board_q[16*r+4*c +: 4] == board_q[16*r+4*c+4 +: 4]) any_pair = 1'b1;
        if (board_q[16*c+4*r +: 4] == board_q[16*c+4*r+16 +: 4]) any_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    score_d      = score_q;
    win_d        = win_q;
    loss_d       = loss_q;
    done_d       = 1'b0;
    dir_d        = dir_q;
    idx_d        = idx_q;
    moved_d      = moved_q;
    from_spawn_d = from_spawn_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      StInit0: begin
        board_d = spawn_board;
        state_d = StInit1;
      end
      StInit1: begin
        board_d = spawn_board;
        state_d = StIdle;
      end
      StIdle, StOver: begin
        if (load) begin
          board_d      = load_board;
          score_d      = '0;
          win_d        = 1'b0;
          loss_d       = 1'b0;
          from_spawn_d = 1'b0;
          state_d      = StCheck;
        end else if (state_q == StIdle && $onehot(dir)) begin
          dir_d   = dir;
          moved_d = 1'b0;
          idx_d   = '0;
          state_d = StSlide;
        end
      end
      StSlide: begin
        board_d = slide_board;
        score_d = (score_sum[18:16] != 3'd0) ? 16'hFFFF : score_sum[15:0];
        moved_d = moved_q | (line_out != line_in);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (moved_d) begin
            state_d = StSpawn;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StSpawn: begin
        board_d      = spawn_board;
        from_spawn_d = 1'b1;
        state_d      = StCheck;
      end
      StCheck: begin
        win_d   = any_win;
        loss_d  = !any_win && !any_empty && !any_pair;
        done_d  = from_spawn_q;
        state_d = (win_d || loss_d) ? StOver : StIdle;
      end
      default: state_d = StInit0;
    endcase

    busy_d = (state_d != StIdle) && (state_d != StOver);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit0;
      board_q      <= '0;
      score_q      <= '0;
      win_q        <= 1'b0;
      loss_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
      lfsr_q       <= LFSR_SEED;
      dir_q        <= '0;
      idx_q        <= '0;
      moved_q      <= 1'b0;
      from_spawn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      score_q      <= score_d;
      win_q        <= win_d;
      loss_q       <= loss_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      lfsr_q       <= lfsr_d;
      dir_q        <= dir_d;
      idx_q        <= idx_d;
      moved_q      <= moved_d;
      from_spawn_q <= from_spawn_d;
    end
  end

  assign board = board_q;
  assign score = score_q;
  assign win   = win_q;
  assign loss  = loss_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_board_move_sequencer.sv
// Randomized bench for board_move_sequencer against a queue-based game model
// with cycle-accurate done/spawn timing.
module tb_board_move_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dir = '0;
    logic        load = 1'b0;
    logic [63:0] load_board = '0;
    logic [63:0] board;
    logic [15:0] score;
    logic        win, loss, busy, done;

    board_move_sequencer #(
        .LFSR_SEED (SEED),
        .WIN_EXP   (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dir        (dir),
        .load       (load),
        .load_board (load_board),
        .board      (board),
        .score      (score),
        .win        (win),
        .loss       (loss),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    logic [63:0] m_board;
    int          m_score;
    logic        m_over;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v, fb;
        v  = int'(s);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) & 32'hFFFF) | fb);
    endfunction

    // Mirror of the generator value the DUT holds in each cycle.
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);

    function automatic int get_cell(input logic [63:0] b, input int i);
        return int'(b[4*i +: 4]);
    endfunction

    function automatic logic [63:0] set_cell(input logic [63:0] b, input int i, input int v);
        logic [63:0] r;
        r = b;
        r[4*i +: 4] = 4'(v);
        return r;
    endfunction

    // dc: 0 left, 1 right, 2 up, 3 down
    function automatic logic [3:0] dir_bits(input int dc);
        case (dc)
            0:       return 4'b0010;
            1:       return 4'b0001;
            2:       return 4'b1000;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic int pos_to_cell(input int dc, input int line, input int p);
        int row, col;
        case (dc)
            0:       begin row = line;  col = p;     end
            1:       begin row = line;  col = 3 - p; end
            2:       begin row = p;     col = line;  end
            default: begin row = 3 - p; col = line;  end
        endcase
        return 4 * row + col;
    endfunction

    function automatic void model_move(input int dc, input logic [63:0] b_in,
                                       output logic [63:0] b_out, output int gain);
        int q[$];
        int res[$];
        int v;
        b_out = b_in;
        gain  = 0;
        for (int line = 0; line < 4; line++) begin
            q.delete();
            res.delete();
            for (int p = 0; p < 4; p++) begin
                v = get_cell(b_in, pos_to_cell(dc, line, p));
                if (v != 0) q.push_back(v);
            end
            while (q.size() > 0) begin
                if (q.size() >= 2 && q[0] == q[1]) begin
                    res.push_back(q[0] + 1);
                    gain += 1 << (q[0] + 1);
                    void'(q.pop_front());
                    void'(q.pop_front());
                end else begin
                    res.push_back(q.pop_front());
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int p = 0; p < 4; p++) b_out = set_cell(b_out, pos_to_cell(dc, line, p), res[p]);
        end
    endfunction

    function automatic logic [63:0] model_spawn(input logic [63:0] b, input logic [15:0] l);
        int start, i;
        start = int'(l[3:0]);
        for (int k = 0; k < 16; k++) begin
            i = (start + k) % 16;
            if (get_cell(b, i) == 0) return set_cell(b, i, (l[7:4] == 4'd0) ? 2 : 1);
        end
        return b;
    endfunction

    function automatic void model_status(input logic [63:0] b, output logic w, output logic lo);
        logic empty, pair;
        int   v;
        w = 1'b0;
        empty = 1'b0;
        pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = get_cell(b, 4 * r + c);
                if (v >= 11) w = 1'b1;
                if (v == 0) empty = 1'b1;
                if (c < 3 && v == get_cell(b, 4 * r + c + 1)) pair = 1'b1;
                if (r < 3 && v == get_cell(b, 4 * r + c + 4)) pair = 1'b1;
            end
        end
        lo = !w && !empty && !pair;
    endfunction

    function automatic logic [63:0] rand_board();
        logic [63:0] b;
        int r;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 15));
            b = set_cell(b, i, (r < 5) ? 0 : (r < 15) ? (r % 4) + 1 : 10);
        end
        return b;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        int nz;
        rst  = 1'b1;
        dir  = '0;
        load = 1'b0;
        tick();
        tick();
        check_val("rst_board", board, 64'd0);
        check_val("rst_score", {48'd0, score}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd1);
        check_val("rst_flags", {61'd0, win, loss, done}, 64'd0);
        rst     = 1'b0;
        m_score = 0;
        m_over  = 1'b0;
        m_board = model_spawn(64'd0, m_lfsr);
        tick();
        check_val("init0_busy", {63'd0, busy}, 64'd1);
        m_board = model_spawn(m_board, m_lfsr);
        tick();
        check_val("init_busy", {63'd0, busy}, 64'd0);
        check_val("init_board", board, m_board);
        check_val("init_score", {48'd0, score}, 64'd0);
        check_val("init_flags", {61'd0, win, loss, done}, 64'd0);
        nz = 0;
        for (int i = 0; i < 16; i++) if (get_cell(board, i) != 0) nz++;
        check_val("init_tiles", 64'(nz), 64'd2);
    endtask

    task automatic do_load(input logic [63:0] b, input logic [3:0] d);
        logic w, lo;
        load       = 1'b1;
        load_board = b;
        dir        = d;
        tick();
        load = 1'b0;
        dir  = '0;
        m_board = b;
        m_score = 0;
        check_val("load_board", board, b);
        check_val("load_busy", {63'd0, busy}, 64'd1);
        check_val("load_done", {63'd0, done}, 64'd0);
        check_val("load_score", {48'd0, score}, 64'd0);
        model_status(b, w, lo);
        tick();
        check_val("load_status", {61'd0, win, loss, done}, {61'd0, w, lo, 1'b0});
        check_val("load_idle", {63'd0, busy}, 64'd0);
        check_val("load_hold", board, b);
        m_over = w | lo;
    endtask

    task automatic do_move(input int dc, input bit noise);
        logic [63:0] exp_b;
        int          gain, done_at;
        logic        moved, w, lo;
        if (m_over) begin
            dir = dir_bits(dc);
            tick();
            dir = '0;
            for (int k = 0; k < 7; k++) begin
                check_val("over_done", {63'd0, done}, 64'd0);
                tick();
            end
            check_val("over_board", board, m_board);
            check_val("over_busy", {63'd0, busy}, 64'd0);
            return;
        end
        model_move(dc, m_board, exp_b, gain);
        moved   = (exp_b != m_board);
        done_at = moved ? 6 : 4;
        dir = dir_bits(dc);
        tick();
        dir = '0;
        check_val("move_busy", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= done_at + 1; k++) begin
            if (noise && k == 2) begin
                dir        = dir_bits(int'($urandom_range(0, 3)));
                load       = 1'b1;
                load_board = rand_board();
            end
            if (k == 3) begin
                dir  = '0;
                load = 1'b0;
            end
            if (moved && k == 5) exp_b = model_spawn(exp_b, m_lfsr);
            tick();
            check_val($sformatf("done_e%0d", k), {63'd0, done}, {63'd0, k == done_at});
        end
        m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
        if (moved) model_status(exp_b, w, lo);
        else begin
            w  = 1'b0;
            lo = 1'b0;
        end
        check_val("move_board", board, exp_b);
        check_val("move_score", {48'd0, score}, 64'(m_score));
        check_val("move_status", {62'd0, win, loss}, {62'd0, w, lo});
        check_val("move_idle", {63'd0, busy}, 64'd0);
        m_board = exp_b;
        m_over  = w | lo;
    endtask

    initial begin
        logic [63:0] b;
        do_reset();

        // Merge of a full row of equal tiles.
        do_load(64'h1111, 4'b0000);
        do_move(0, 1'b0);
        check_val("merge_row0", {56'd0, board[7:0]}, 64'h22);
        check_val("merge_score", {48'd0, score}, 64'd8);

        // No movement possible: no spawn, early done.
        do_load(64'h1, 4'b0000);
        do_move(0, 1'b1);
        check_val("nomove_board", board, 64'h1);

        // Win, then moves ignored in OVER.
        do_load(64'hAA, 4'b0000);
        do_move(0, 1'b0);
        check_val("win_flag", {63'd0, win}, 64'd1);
        check_val("win_score", {48'd0, score}, 64'd2048);
        check_val("win_cell0", 64'(get_cell(board, 0)), 64'd11);
        do_move(2, 1'b0);

        // Checkerboard loss, loaded from OVER.
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b = set_cell(b, 4 * r + c, ((r + c) % 2 == 1) ? 2 : 1);
        do_load(b, 4'b0000);
        check_val("loss_flag", {63'd0, loss}, 64'd1);

        // Load from IDLE wins over a simultaneous move request.
        do_load(64'h1111, 4'b0000);
        do_load(64'h0202, 4'b0010);

        // Multi-hot request is ignored.
        dir = 4'b0011;
        tick();
        dir = '0;
        for (int k = 0; k < 3; k++) begin
            check_val("multihot_busy", {62'd0, busy, done}, 64'd0);
            tick();
        end
        check_val("multihot_board", board, m_board);

        repeat (60) begin
            if (m_over || $urandom_range(0, 4) == 0)
                do_load(rand_board(), ($urandom_range(0, 1) == 1) ? 4'b0100 : 4'b0000);
            else
                do_move(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a slide.
        do_load(64'h1111, 4'b0000);
        dir = 4'b0010;
        tick();
        dir = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("abort_board", board, 64'd0);
        check_val("abort_score", {48'd0, score}, 64'd0);
        check_val("abort_busy", {63'd0, busy}, 64'd1);
        do_reset();
        do_move(int'($urandom_range(0, 3)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
